// File: rtl/up_counter_pkg.sv
// Shared definitions for the up_counter block: the controller state
// encoding and the default counter width.
package up_counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Clamp a requested load value to the terminal value.
  function automatic logic [DEFAULT_WIDTH-1:0] clamp_default(
    input logic [DEFAULT_WIDTH-1:0] val,
    input logic [DEFAULT_WIDTH-1:0] lim
  );
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/up_counter.sv
// Programmable up-counter with terminal value, wrap or one-shot stop,
// synchronous clear/load and a registered terminal-count pulse.
// Control priority on each edge: clear, then load, then enabled increment,
// otherwise hold. busy/done are pure state decodes.
module up_counter
  import up_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             tc_reg, tc_next;
  logic             at_max;

  // Terminal compare plus next-state / next-count selection.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    tc_next    = 1'b0;
    // ">=" rather than "==" so a max_val lowered below the count still
    // terminates at the next enabled edge.
    at_max     = (count_reg >= max_val);

    if (clear) begin
      count_next = '0;
      state_next = IDLE;
    end else if (load) begin
      count_next = (load_val > max_val) ? max_val : load_val;
      state_next = IDLE;
    end else if (state_reg != DONE) begin
      if (enable) begin
        if (!at_max) begin
          count_next = count_reg + WIDTH'(1);
          state_next = COUNT;
        end else if (one_shot) begin
          count_next = max_val;
          state_next = DONE;
          tc_next    = 1'b1;
        end else begin
          count_next = '0;
          state_next = COUNT;
          tc_next    = 1'b1;
        end
      end else if (state_reg == COUNT) begin
        state_next = IDLE;
      end
    end
  end

  // Single registered process for state, count and terminal-count pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      tc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      tc_reg    <= tc_next;
    end
  end

  assign count = count_reg;
  assign tc    = tc_reg;
  assign busy  = (state_reg == COUNT);
  assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_up_counter.sv
// Directed, table-driven bench for up_counter (WIDTH = 8). Vectors are
// applied in order on one continuous run; each record carries the inputs
// for one edge and the outputs expected right after it.
module tb_up_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] max_val = '0;
  logic         one_shot = 1'b0;
  logic [W-1:0] count;
  logic         tc, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         clr;
    logic         ld;
    logic         en;
    logic         os;
    logic [W-1:0] lv;
    logic [W-1:0] mv;
    logic [W-1:0] exp_count;
    logic         exp_tc;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  vec_t vecs[$];

  up_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .one_shot (one_shot),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic add(input logic clr, input logic ld, input logic en, input logic os,
                     input int lv, input int mv, input int ec,
                     input logic et, input logic eb, input logic ed);
    vec_t v;
    v.clr = clr; v.ld = ld; v.en = en; v.os = os;
    v.lv = W'(lv); v.mv = W'(mv); v.exp_count = W'(ec);
    v.exp_tc = et; v.exp_busy = eb; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int ec,
                       input logic et, input logic eb, input logic ed);
    n_tests++;
    if (count !== W'(ec) || tc !== et || busy !== eb || done !== ed) begin
      n_fail++;
      $display("[TB] FAIL %s: got count=%0d tc=%b busy=%b done=%b, want count=%0d tc=%b busy=%b done=%b",
               name, count, tc, busy, done, ec, et, eb, ed);
    end else begin
      $display("[TB] ok   %s: count=%0d tc=%b busy=%b done=%b", name, count, tc, busy, done);
    end
  endtask

  // One clocked step: drive on the falling edge, sample 1 time unit after rising.
  task automatic step(input logic clr, input logic ld, input logic en, input logic os,
                      input int lv, input int mv);
    @(negedge clk);
    clear = clr; load = ld; enable = en; one_shot = os;
    load_val = W'(lv); max_val = W'(mv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Vector table (continuous run from reset).
    // Ten enabled edges, large terminal value: no tc.
    for (int i = 1; i <= 10; i++) add(0,0,1,0, 0,255, i, 0,1,0);
    add(1,0,0,0, 0,255, 0, 0,0,0);                         // clear
    // Wrap at 5.
    for (int i = 1; i <= 5; i++) add(0,0,1,0, 0,5, i, 0,1,0);
    add(0,0,1,0, 0,5, 0, 1,1,0);                           // wrap with tc
    add(0,0,1,0, 0,5, 1, 0,1,0);                           // tc lasts one cycle
    add(1,0,0,0, 0,3, 0, 0,0,0);
    // One-shot stop at 3.
    for (int i = 1; i <= 3; i++) add(0,0,1,1, 0,3, i, 0,1,0);
    add(0,0,1,1, 0,3, 3, 1,0,1);                           // enter DONE with tc
    for (int i = 0; i < 4; i++) add(0,0,1,1, 0,3, 3, 0,0,1);
    add(0,1,1,1, 1,3, 1, 0,0,0);                           // load exits DONE
    // clear beats load; load clamps to max_val.
    add(1,1,0,0, 200,100, 0, 0,0,0);
    add(0,1,0,0, 200,100, 100, 0,0,0);
    add(0,1,0,0, 50,100, 50, 0,0,0);
    add(1,0,0,0, 0,255, 0, 0,0,0);
    // Enable dropped at 4 for four cycles, then restored.
    for (int i = 1; i <= 4; i++) add(0,0,1,0, 0,255, i, 0,1,0);
    for (int i = 0; i < 4; i++) add(0,0,0,0, 0,255, 4, 0,0,0);
    add(0,0,1,0, 0,255, 5, 0,1,0);
    // max_val = 0 in wrap mode: stuck at 0 with tc every enabled cycle.
    for (int i = 0; i < 3; i++) add(0,0,1,0, 0,0, 0, 1,1,0);
    add(0,0,0,0, 0,0, 0, 0,0,0);
    // Lowering max_val below count.
    add(0,1,0,0, 6,255, 6, 0,0,0);
    add(0,0,1,0, 0,3, 0, 1,1,0);                           // wrap mode
    add(0,1,0,0, 6,255, 6, 0,0,0);
    add(0,0,1,1, 0,2, 2, 1,0,1);                           // one-shot clamps to max
    add(0,0,1,1, 0,2, 2, 0,0,1);
    // Full-range wrap and stop at 2^W-1.
    add(0,1,0,0, 254,255, 254, 0,0,0);
    add(0,0,1,0, 0,255, 255, 0,1,0);
    add(0,0,1,0, 0,255, 0, 1,1,0);
    add(0,1,0,0, 254,255, 254, 0,0,0);
    add(0,0,1,1, 0,255, 255, 0,1,0);
    add(0,0,1,1, 0,255, 255, 1,0,1);
    add(0,0,0,1, 0,255, 255, 0,0,1);                       // DONE holds with enable low

    // Asynchronous reset from t=1, checked before any clock edge.
    #1 reset = 1'b0;
    #2;
    check("reset_async", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].os, vecs[i].lv, vecs[i].mv);
      check($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_tc,
            vecs[i].exp_busy, vecs[i].exp_done);
    end

    // Mid-cycle reset at count 7.
    step(1,0,0,0, 0,255);
    for (int i = 0; i < 7; i++) step(0,0,1,0, 0,255);
    check("pre_reset_7", 7, 0, 1, 0);
    #2 reset = 1'b0;
    #1;
    check("reset_midcycle", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("reset_held", 0, 0, 0, 0);
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < 3; i++) step(0,0,1,0, 0,255);
    check("after_reset_3", 3, 0, 1, 0);

    // Reset while in DONE.
    step(0,1,0,1, 1,1);
    step(0,0,1,1, 0,1);
    check("done_before_reset", 1, 1, 0, 1);
    #2 reset = 1'b0;
    #1;
    check("reset_in_done", 0, 0, 0, 0);
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    step(0,0,1,0, 0,255);
    check("resume_from_0", 1, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
